// File: rtl/alu_arb_pkg.sv
// -----------------------------------------------------------------------------
// alu_arb_pkg
//   Shared definitions for the two-requester ALU arbiter:
//     - default datapath / instruction / PC widths
//     - 5-bit opcode encodings (opcode lives in insn[INSN:INSN-4])
//     - requester id type
//     - is_carry_op(): opcodes whose carry-out is architecturally visible
// -----------------------------------------------------------------------------
package alu_arb_pkg;

    localparam int WORD_SIZE_DEF = 256;
    localparam int INSN_DEF      = 19;
    localparam int IADDR_DEF     = 10;
    localparam int OPC_W         = 5;

    // Requester 0 or 1.
    typedef logic req_id_t;

    typedef enum logic [OPC_W-1:0] {
        OP_AND  = 5'b00000,
        OP_OR   = 5'b00001,
        OP_XOR  = 5'b00010,
        OP_NOT  = 5'b00011,
        OP_MOV  = 5'b00100,
        OP_ADD  = 5'b00101,  // r1 + r2 + cin
        OP_SUB  = 5'b00110,  // r1 + ~r2 + cin (subtract with carry-as-not-borrow)
        OP_ADDI = 5'b00111,  // r1 + sext(imm) + cin
        OP_PC   = 5'b01000,  // zero-extended pc
        OP_TCS  = 5'b10100,  // ~r1 + cin (negate when cin=1)
        OP_TCDH = 5'b10101   // r1 + r1 + cin (shift left through carry)
    } opcode_e;

    function automatic logic is_carry_op(input logic [OPC_W-1:0] opc);
        return (opc == OP_ADD)  || (opc == OP_SUB) || (opc == OP_ADDI) ||
               (opc == OP_TCS)  || (opc == OP_TCDH);
    endfunction

endpackage

// File: rtl/alu_arb_if.sv
// -----------------------------------------------------------------------------
// alu_arb_if
//   Request/response bundle between the two requesters + consumer (master)
//   and the shared-ALU arbiter (slave).
//     req_valid/req_ready[1:0]   per-requester handshake
//     reqN_insn/pc/r1/r2         per-requester instruction and operands
//     req_cin_clr[1:0]           per-requester carry-in force-to-zero
//     rsp_valid/rsp_ready        response handshake
//     rsp_id/result/carry        response payload
// -----------------------------------------------------------------------------
interface alu_arb_if
    import alu_arb_pkg::*;
#(
    parameter int WORD_SIZE = WORD_SIZE_DEF,
    parameter int INSN      = INSN_DEF,
    parameter int IADDR     = IADDR_DEF
);
    logic [1:0]           req_valid;
    logic [1:0]           req_ready;
    logic [INSN:0]        req0_insn;
    logic [INSN:0]        req1_insn;
    logic [IADDR:0]       req0_pc;
    logic [IADDR:0]       req1_pc;
    logic [WORD_SIZE-1:0] req0_r1;
    logic [WORD_SIZE-1:0] req0_r2;
    logic [WORD_SIZE-1:0] req1_r1;
    logic [WORD_SIZE-1:0] req1_r2;
    logic [1:0]           req_cin_clr;
    logic                 rsp_valid;
    logic                 rsp_ready;
    req_id_t              rsp_id;
    logic [WORD_SIZE-1:0] rsp_result;
    logic                 rsp_carry;

    modport master (
        output req_valid, req0_insn, req1_insn, req0_pc, req1_pc,
               req0_r1, req0_r2, req1_r1, req1_r2, req_cin_clr, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_carry
    );

    modport slave (
        input  req_valid, req0_insn, req1_insn, req0_pc, req1_pc,
               req0_r1, req0_r2, req1_r1, req1_r2, req_cin_clr, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_result, rsp_carry
    );
endinterface

// File: rtl/alu_arb_lc4_alu.sv
// -----------------------------------------------------------------------------
// lc4_alu
//   Purely combinational ALU shared by both requesters.
//   Ports:
//     insn      instruction; opcode = insn[INSN:INSN-4], imm = insn[INSN-5:0]
//     pc        program counter (OP_PC result)
//     r1, r2    operands
//     cin       carry input for the carry opcodes
//     result    ALU result
//     carry_out carry-out of the adder for carry opcodes, 0 otherwise
// -----------------------------------------------------------------------------
module lc4_alu
    import alu_arb_pkg::*;
#(
    parameter int WORD_SIZE = WORD_SIZE_DEF,
    parameter int INSN      = INSN_DEF,
    parameter int IADDR     = IADDR_DEF
) (
    input  logic [INSN:0]        insn,
    input  logic [IADDR:0]       pc,
    input  logic [WORD_SIZE-1:0] r1,
    input  logic [WORD_SIZE-1:0] r2,
    input  logic                 cin,
    output logic [WORD_SIZE-1:0] result,
    output logic                 carry_out
);
    localparam int IMM_W = INSN + 1 - OPC_W;

    opcode_e              opc;
    logic [WORD_SIZE-1:0] imm_sext;
    logic [WORD_SIZE-1:0] add_a;
    logic [WORD_SIZE-1:0] add_b;
    logic [WORD_SIZE:0]   sum;

    assign opc      = opcode_e'(insn[INSN -: OPC_W]);
    assign imm_sext = {{(WORD_SIZE-IMM_W){insn[IMM_W-1]}}, insn[IMM_W-1:0]};

    // All carry opcodes are folded onto one adder by choosing its operands.
    always_comb begin
        add_a = r1;
        add_b = r2;
        case (opc)
            OP_SUB:  add_b = ~r2;
            OP_ADDI: add_b = imm_sext;
            OP_TCS: begin
                add_a = '0;
                add_b = ~r1;
            end
            OP_TCDH: add_b = r1;
            default: ;
        endcase
    end

    assign sum = {1'b0, add_a} + {1'b0, add_b} + {{WORD_SIZE{1'b0}}, cin};

    always_comb begin
        result    = '0;
        carry_out = 1'b0;
        case (opc)
            OP_AND:  result = r1 & r2;
            OP_OR:   result = r1 | r2;
            OP_XOR:  result = r1 ^ r2;
            OP_NOT:  result = ~r1;
            OP_MOV:  result = r2;
            OP_PC:   result = {{(WORD_SIZE-IADDR-1){1'b0}}, pc};
            OP_ADD, OP_SUB, OP_ADDI, OP_TCS, OP_TCDH: begin
                result    = sum[WORD_SIZE-1:0];
                carry_out = sum[WORD_SIZE];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_arb.sv
// -----------------------------------------------------------------------------
// alu_arb
//   Shares one lc4_alu between two requesters. Round-robin arbitration when
//   both are valid, one grant per cycle, a single response register
//   (latency 1, full throughput when the consumer drains every cycle).
//   Ports:
//     clk     rising-edge clock
//     rst_n   asynchronous active-low reset
//     bus     alu_arb_if.slave: request handshakes + payloads, response
//   Build option:
//     ALU_ARB_CARRY_EN  defined   -> per-requester carry flags feed the ALU
//                                    carry input (req_cin_clr forces it to 0)
//                       undefined -> ALU carry input tied 0, no carry flags
// -----------------------------------------------------------------------------
module alu_arb
    import alu_arb_pkg::*;
#(
    parameter int WORD_SIZE = WORD_SIZE_DEF,
    parameter int INSN      = INSN_DEF,
    parameter int IADDR     = IADDR_DEF
) (
    input  logic     clk,
    input  logic     rst_n,
    alu_arb_if.slave bus
);

    // ---------------- state ----------------
    req_id_t              ptr_q, ptr_d;        // round-robin favourite
    logic                 rdy_en_q, rdy_en_d;  // low until first edge after reset
    logic                 rsp_valid_q, rsp_valid_d;
    req_id_t              rsp_id_q, rsp_id_d;
    logic [WORD_SIZE-1:0] rsp_result_q, rsp_result_d;
    logic                 rsp_carry_q, rsp_carry_d;

    // ---------------- arbitration ----------------
    logic [1:0]           grant;
    logic                 slot_free;
    logic                 xfer;
    req_id_t              gid;

    always_comb begin
        grant = 2'b00;
        case (bus.req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = ptr_q ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    // rdy_en_q is cleared asynchronously, so req_ready drops the moment reset
    // asserts and stays low through the first edge after release.
    assign slot_free     = !rsp_valid_q || bus.rsp_ready;
    assign bus.req_ready = (rdy_en_q && slot_free) ? grant : 2'b00;
    assign xfer          = |bus.req_ready;
    assign gid           = grant[1];

    // ---------------- operand mux + ALU ----------------
    logic [INSN:0]        sel_insn;
    logic [IADDR:0]       sel_pc;
    logic [WORD_SIZE-1:0] sel_r1;
    logic [WORD_SIZE-1:0] sel_r2;
    logic                 alu_cin;
    logic [WORD_SIZE-1:0] alu_result;
    logic                 alu_cout;
    logic                 carry_op;

    assign sel_insn = gid ? bus.req1_insn : bus.req0_insn;
    assign sel_pc   = gid ? bus.req1_pc   : bus.req0_pc;
    assign sel_r1   = gid ? bus.req1_r1   : bus.req0_r1;
    assign sel_r2   = gid ? bus.req1_r2   : bus.req0_r2;
    assign carry_op = is_carry_op(sel_insn[INSN -: OPC_W]);

    lc4_alu #(
        .WORD_SIZE (WORD_SIZE),
        .INSN      (INSN),
        .IADDR     (IADDR)
    ) u_alu (
        .insn      (sel_insn),
        .pc        (sel_pc),
        .r1        (sel_r1),
        .r2        (sel_r2),
        .cin       (alu_cin),
        .result    (alu_result),
        .carry_out (alu_cout)
    );

    // ---------------- carry flags ----------------
`ifdef ALU_ARB_CARRY_EN
    logic [1:0] cf_q, cf_d;

    // Each requester sees only its own flag. A carry opcode always records
    // its carry-out, even when its carry-in was forced to zero.
    always_comb begin
        alu_cin = bus.req_cin_clr[gid] ? 1'b0 : cf_q[gid];
        cf_d    = cf_q;
        if (xfer && carry_op) begin
            cf_d[gid] = alu_cout;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cf_q <= 2'b00;
        end else begin
            cf_q <= cf_d;
        end
    end
`else
    logic unused_cin_clr;

    assign alu_cin        = 1'b0;
    assign unused_cin_clr = ^bus.req_cin_clr;
`endif

    // ---------------- response register + pointer ----------------
    always_comb begin
        rdy_en_d     = 1'b1;
        ptr_d        = ptr_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_carry_d  = rsp_carry_q;
        if (xfer) begin
            // Reload covers the drain-and-refill case: valid stays high.
            ptr_d        = ~gid;
            rsp_valid_d  = 1'b1;
            rsp_id_d     = gid;
            rsp_result_d = alu_result;
            rsp_carry_d  = carry_op ? alu_cout : 1'b0;
        end else if (bus.rsp_ready) begin
            rsp_valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_en_q     <= 1'b0;
            ptr_q        <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_carry_q  <= 1'b0;
        end else begin
            rdy_en_q     <= rdy_en_d;
            ptr_q        <= ptr_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_carry_q  <= rsp_carry_d;
        end
    end

    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_carry  = rsp_carry_q;

endmodule

// File: tb/tb_alu_arb.sv
// -----------------------------------------------------------------------------
// tb_alu_arb
//   Scoreboard bench for alu_arb. The driver computes expected grants and
//   responses from an arithmetic reference model and queues them; a separate
//   monitor compares the response register against the queue every cycle.
// -----------------------------------------------------------------------------
module tb_alu_arb;
    import alu_arb_pkg::*;

    localparam int WS = 256;
    localparam int IN = 19;
    localparam int IA = 10;
    localparam logic [4:0] OP_TAB [12] = '{5'b00000, 5'b00001, 5'b00010, 5'b00011,
                                          5'b00100, 5'b00101, 5'b00110, 5'b00111,
                                          5'b01000, 5'b10100, 5'b10101, 5'b11111};

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_arb_if #(.WORD_SIZE(WS), .INSN(IN), .IADDR(IA)) bus ();

    alu_arb #(.WORD_SIZE(WS), .INSN(IN), .IADDR(IA)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic          id;
        logic [WS-1:0] result;
        logic          carry;
    } rsp_t;

    rsp_t          q[$];
    int            checks = 0;
    int            errors = 0;
    logic          m_ptr;
    logic [1:0]    m_cf;
    logic          m_rdy;
    logic [1:0]    last_ready;
    logic          last_valid;
    logic [WS-1:0] last_res;
    logic          last_carry;
    logic          last_id;

    task automatic chk(input string name, input logic [WS-1:0] act, input logic [WS-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic is_cop(input logic [4:0] opc);
        return opc inside {5'b00101, 5'b00110, 5'b00111, 5'b10100, 5'b10101};
    endfunction

    // Reference ALU: returns {carry, result} using plain wide arithmetic.
    function automatic logic [WS:0] model_alu(input logic [IN:0] insn, input logic [IA:0] pc,
                                              input logic [WS-1:0] a, input logic [WS-1:0] b,
                                              input logic cin);
        logic [4:0]    opc;
        logic [14:0]   imm;
        logic [WS+1:0] wa, wb, wi, t;
        logic [WS-1:0] res;
        logic          cy;
        opc = insn[IN -: 5];
        imm = insn[14:0];
        wa  = {2'b00, a};
        wb  = {2'b00, b};
        // signed immediate as a 2^WS-modular pattern
        wi  = imm[14] ? (((WS+2)'(1) << WS) - (WS+2)'(32768) + (WS+2)'(imm)) : (WS+2)'(imm);
        res = '0;
        cy  = 1'b0;
        t   = '0;
        case (opc)
            5'b00000: res = a & b;
            5'b00001: res = a | b;
            5'b00010: res = a ^ b;
            5'b00011: res = ~a;
            5'b00100: res = b;
            5'b01000: res = WS'(pc);
            5'b00101: begin t = wa + wb + (WS+2)'(cin); res = t[WS-1:0]; cy = t[WS]; end
            5'b00110: begin
                res = a - b - WS'(!cin);
                cy  = (wa >= wb + (WS+2)'(!cin));
            end
            5'b00111: begin t = wa + wi + (WS+2)'(cin); res = t[WS-1:0]; cy = t[WS]; end
            5'b10100: begin res = WS'(0) - a - WS'(1) + WS'(cin); cy = (a == '0) && cin; end
            5'b10101: begin t = wa * 2 + (WS+2)'(cin); res = t[WS-1:0]; cy = t[WS]; end
            default: ;
        endcase
        return {cy, res};
    endfunction

    function automatic logic [WS-1:0] rand_word();
        logic [WS-1:0] w;
        w = '0;
        case ($urandom_range(7))
            0:       w = '0;
            1:       w = '1;
            default: for (int k = 0; k < WS/32; k++) w[k*32 +: 32] = $urandom;
        endcase
        return w;
    endfunction

    task automatic set_req(input int i, input logic [4:0] opc, input logic [WS-1:0] a,
                           input logic [WS-1:0] b, input logic clr);
        logic [IN:0] insn;
        insn = {opc, 15'($urandom)};
        if (i == 0) begin
            bus.req0_insn = insn; bus.req0_pc = 11'($urandom);
            bus.req0_r1 = a; bus.req0_r2 = b;
        end else begin
            bus.req1_insn = insn; bus.req1_pc = 11'($urandom);
            bus.req1_r1 = a; bus.req1_r2 = b;
        end
        bus.req_cin_clr[i] = clr;
    endtask

    task automatic model_reset();
        q.delete();
        m_ptr = 1'b0;
        m_cf  = 2'b00;
        m_rdy = 1'b0;
    endtask

    // Called at a negedge with inputs already applied; returns at the next negedge.
    task automatic step();
        logic [1:0]    exp_ready;
        logic          xfer, gid, cin, cop;
        logic [IN:0]   insn;
        logic [IA:0]   pc;
        logic [WS-1:0] a, b;
        logic [WS:0]   r;
        rsp_t          e;
        #1;
        exp_ready = 2'b00;
        if (m_rdy && (q.size() == 0 || bus.rsp_ready)) begin
            if (bus.req_valid == 2'b11) exp_ready = m_ptr ? 2'b10 : 2'b01;
            else                        exp_ready = bus.req_valid;
        end
        last_ready = bus.req_ready;
        chk("req_ready", WS'(bus.req_ready), WS'(exp_ready));
        xfer = (exp_ready != 2'b00);
        gid  = exp_ready[1];
        cop  = 1'b0;
        r    = '0;
        e    = '{id: 1'b0, result: '0, carry: 1'b0};
        if (xfer) begin
            insn = gid ? bus.req1_insn : bus.req0_insn;
            pc   = gid ? bus.req1_pc   : bus.req0_pc;
            a    = gid ? bus.req1_r1   : bus.req0_r1;
            b    = gid ? bus.req1_r2   : bus.req0_r2;
            cop  = is_cop(insn[IN -: 5]);
`ifdef ALU_ARB_CARRY_EN
            cin  = bus.req_cin_clr[gid] ? 1'b0 : m_cf[gid];
`else
            cin  = 1'b0;
`endif
            r    = model_alu(insn, pc, a, b, cin);
            e    = '{id: gid, result: r[WS-1:0], carry: cop ? r[WS] : 1'b0};
        end
        @(posedge clk);
        #1;
        last_valid = bus.rsp_valid;
        last_res   = bus.rsp_result;
        last_carry = bus.rsp_carry;
        last_id    = bus.rsp_id;
        if (xfer) begin
            q.push_back(e);
            m_ptr = ~gid;
            if (cop) m_cf[gid] = r[WS];
        end
        m_rdy = 1'b1;
        @(negedge clk);
    endtask

    // Monitor: the response register must always match the queue head.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                chk("rsp_valid_in_reset", WS'(bus.rsp_valid), '0);
            end else begin
                chk("rsp_valid", WS'(bus.rsp_valid), WS'(q.size() != 0));
                if (bus.rsp_valid && q.size() != 0) begin
                    chk("rsp_id",     WS'(bus.rsp_id),    WS'(q[0].id));
                    chk("rsp_result", bus.rsp_result,     q[0].result);
                    chk("rsp_carry",  WS'(bus.rsp_carry), WS'(q[0].carry));
                    if (bus.rsp_ready) void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        logic [WS-1:0] hold;
        logic [1:0]    pat [4];
        pat = '{2'b01, 2'b10, 2'b01, 2'b10};
        rst_n = 1'b1;
        bus.req_valid = 2'b00; bus.req_cin_clr = 2'b00; bus.rsp_ready = 1'b1;
        bus.req0_insn = '0; bus.req1_insn = '0; bus.req0_pc = '0; bus.req1_pc = '0;
        bus.req0_r1 = '0; bus.req0_r2 = '0; bus.req1_r1 = '0; bus.req1_r2 = '0;
        model_reset();
        #1 rst_n = 1'b0;
        bus.req_valid = 2'b11;
        @(negedge clk);
        #1;
        chk("reset_rsp_valid",  WS'(bus.rsp_valid), '0);
        chk("reset_rsp_id",     WS'(bus.rsp_id), '0);
        chk("reset_rsp_result", bus.rsp_result, '0);
        chk("reset_rsp_carry",  WS'(bus.rsp_carry), '0);
        chk("reset_req_ready",  WS'(bus.req_ready), '0);
        @(negedge clk);
        rst_n = 1'b1;

        // Both valid, ADD 5+3: first edge after release grants nothing, then 0,1,0,1.
        set_req(0, 5'b00101, WS'(5), WS'(3), 1'b0);
        set_req(1, 5'b00101, WS'(5), WS'(3), 1'b0);
        step();
        chk("first_edge_no_grant", WS'(last_ready), '0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("rr_grant",  WS'(last_ready), WS'(pat[k]));
            chk("rr_result", last_res, WS'(8));
            chk("rr_id",     WS'(last_id), WS'(k % 2));
        end

        // Carry propagation through requester 0's flag.
        bus.req_valid = 2'b01;
        set_req(0, 5'b00101, '1, WS'(1), 1'b0);
        step();
        chk("ovf_result", last_res, '0);
        chk("ovf_carry",  WS'(last_carry), WS'(1));
        set_req(0, 5'b00101, '0, '0, 1'b0);
        step();
`ifdef ALU_ARB_CARRY_EN
        chk("cf_used", last_res, WS'(1));
`else
        chk("cf_absent", last_res, '0);
`endif

        // Carry set again, req1 interleaved, then req0 with carry-in forced off.
        set_req(0, 5'b00101, '1, WS'(1), 1'b0);
        step();
        bus.req_valid = 2'b10;
        set_req(1, 5'b00101, '0, '0, 1'b0);
        step();
        chk("cf_isolated", last_res, '0);
        bus.req_valid = 2'b01;
        set_req(0, 5'b00101, '0, '0, 1'b1);
        step();
        chk("cin_clr", last_res, '0);

        // Back-pressure: no grants while the register is full and undrained.
        bus.req_valid = 2'b11;
        set_req(0, 5'b00110, rand_word(), rand_word(), 1'b0);
        set_req(1, 5'b00111, rand_word(), rand_word(), 1'b0);
        bus.rsp_ready = 1'b0;
        hold = last_res;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("stall_ready",  WS'(last_ready), '0);
            chk("stall_valid",  WS'(last_valid), WS'(1));
            chk("stall_stable", last_res, hold);
        end
        bus.rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("release_grant", WS'(|last_ready), WS'(1));
        end

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            bus.req_valid = 2'($urandom);
            bus.rsp_ready = ($urandom_range(3) != 0);
            set_req(0, OP_TAB[$urandom_range(11)], rand_word(), rand_word(), $urandom_range(3) == 0);
            set_req(1, OP_TAB[$urandom_range(11)], rand_word(), rand_word(), $urandom_range(3) == 0);
            step();
        end

        // Mid-stream reset with a pending response and req0's carry set.
        bus.rsp_ready = 1'b1;
        bus.req_valid = 2'b01;
        set_req(0, 5'b00101, '1, WS'(1), 1'b0);
        step();
        bus.rsp_ready = 1'b0;
        bus.req_valid = 2'b11;
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_rsp_valid",  WS'(bus.rsp_valid), '0);
        chk("midrst_rsp_result", bus.rsp_result, '0);
        chk("midrst_req_ready",  WS'(bus.req_ready), '0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        bus.rsp_ready = 1'b1;
        set_req(0, 5'b00101, '0, '0, 1'b0);
        set_req(1, 5'b00101, WS'(7), WS'(7), 1'b0);
        step();
        chk("midrst_first_edge", WS'(last_ready), '0);
        step();
        chk("midrst_ptr0",    WS'(last_ready), WS'(2'b01));
        chk("midrst_cf_clr",  last_res, '0);

        // Drain.
        bus.req_valid = 2'b00;
        for (int k = 0; k < 3; k++) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
